// File: rtl/nts_dispatch_pkg.sv
// Shared definitions for the NTS dispatcher path: RX buffer FSM encoding, word and
// byte-mask widths, and a saturating counter helper.
package nts_dispatch_pkg;

  localparam int WORD_W             = 64;
  localparam int MASK_W             = 8;
  localparam int STAT_W             = 32;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DROP  = 2'd2,
    S_READY = 2'd3
  } rx_state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/nts_rx_buffer_ram.sv
// Single-packet storage: one registered write port, one combinational read port so the
// buffer can present its current word first-word-fall-through.
module nts_rx_buffer_ram
  import nts_dispatch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [WORD_W-1:0]     i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [WORD_W-1:0]     o_rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/nts_rx_packet_buffer.sv
// Receive-side single-frame buffer between the MAC RX stream and the nts_engine dispatcher.
// Optional frame statistics are built when NTS_RX_BUFFER_STATS_EN is defined.
module nts_rx_packet_buffer
  import nts_dispatch_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic              i_clk,
  input  logic              i_areset,
  input  logic              i_mac_rx_valid,
  input  logic [WORD_W-1:0] i_mac_rx_data,
  input  logic              i_mac_rx_last,
  input  logic [MASK_W-1:0] i_mac_rx_bytes,
  input  logic              i_mac_rx_error,
  output logic              o_packet_available,
  input  logic              i_packet_read_discard,
  output logic [MASK_W-1:0] o_data_valid,
  output logic              o_fifo_empty,
  input  logic              i_fifo_rd_en,
  output logic [WORD_W-1:0] o_fifo_rd_data,
`ifdef NTS_RX_BUFFER_STATS_EN
  output logic [STAT_W-1:0] o_stat_accepted,
  output logic [STAT_W-1:0] o_stat_dropped,
`endif
  output rx_state_t         o_dbg_state
);

  // Handshake: the MAC side has no backpressure, a word is consumed on every cycle
  // i_mac_rx_valid is high; the engine pops with i_fifo_rd_en, which only advances
  // while o_fifo_empty is low and the state is S_READY.
  localparam logic [ADDR_WIDTH:0]   WR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] RD_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  rx_state_t             r_state;
  rx_state_t             w_next_state;
  logic [ADDR_WIDTH:0]   r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_last_ptr;
  logic [MASK_W-1:0]     r_bytes;
  logic                  r_side_busy;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_overflow;
  logic                  w_ready;
  logic [WORD_W-1:0]     w_rd_data;

  assign w_overflow = r_wr_ptr[ADDR_WIDTH];
  assign w_ready    = (r_state == S_READY);

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_waddr      = r_wr_ptr[ADDR_WIDTH-1:0];
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mac_rx_valid) begin
          w_we    = 1'b1;
          w_waddr = '0;
          if (!i_mac_rx_last) begin
            w_next_state = S_RECV;
          end else if (i_mac_rx_error) begin
            w_drop = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = S_READY;
          end
        end
      end
      S_RECV: begin
        if (i_mac_rx_valid) begin
          if (w_overflow) begin
            w_drop       = 1'b1;
            w_next_state = i_mac_rx_last ? S_IDLE : S_DROP;
          end else begin
            w_we = 1'b1;
            if (i_mac_rx_last && i_mac_rx_error) begin
              w_drop       = 1'b1;
              w_next_state = S_IDLE;
            end else if (i_mac_rx_last) begin
              w_accept     = 1'b1;
              w_next_state = S_READY;
            end
          end
        end
      end
      S_DROP: begin
        if (i_mac_rx_valid && i_mac_rx_last) begin
          w_next_state = S_IDLE;
        end
      end
      S_READY: begin
        // A frame arriving while one is held is counted once, on its first word.
        if (i_mac_rx_valid && !r_side_busy) begin
          w_drop = 1'b1;
        end
        // Releasing mid-way through such a frame must still swallow its remainder.
        if (i_packet_read_discard) begin
          if (i_mac_rx_valid) begin
            w_next_state = i_mac_rx_last ? S_IDLE : S_DROP;
          end else begin
            w_next_state = r_side_busy ? S_DROP : S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last_ptr  <= '0;
      r_bytes     <= '0;
      r_side_busy <= 1'b0;
    end else begin
      if (r_state == S_IDLE && i_mac_rx_valid) begin
        r_wr_ptr <= WR_ONE;
      end else if (r_state == S_RECV && i_mac_rx_valid && !w_overflow) begin
        r_wr_ptr <= r_wr_ptr + WR_ONE;
      end
      if (w_accept) begin
        r_last_ptr <= w_waddr;
        r_bytes    <= i_mac_rx_bytes;
      end
      if (w_ready) begin
        if (i_packet_read_discard) begin
          r_rd_ptr <= '0;
        end else if (i_fifo_rd_en && (r_rd_ptr != r_last_ptr)) begin
          r_rd_ptr <= r_rd_ptr + RD_ONE;
        end
        if (i_mac_rx_valid) begin
          r_side_busy <= !i_mac_rx_last;
        end
      end else begin
        r_rd_ptr    <= '0;
        r_side_busy <= 1'b0;
      end
    end
  end

  nts_rx_buffer_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(i_mac_rx_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_rd_data)
  );

  assign o_packet_available = w_ready;
  assign o_data_valid       = w_ready ? r_bytes : '0;
  assign o_fifo_empty       = !w_ready || (r_rd_ptr == r_last_ptr);
  assign o_fifo_rd_data     = w_ready ? w_rd_data : '0;
  assign o_dbg_state        = r_state;

`ifdef NTS_RX_BUFFER_STATS_EN
  logic [STAT_W-1:0] r_stat_accepted;
  logic [STAT_W-1:0] r_stat_dropped;

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_stat_accepted <= '0;
      r_stat_dropped  <= '0;
    end else begin
      if (w_accept) begin
        r_stat_accepted <= sat_inc(r_stat_accepted);
      end
      if (w_drop) begin
        r_stat_dropped <= sat_inc(r_stat_dropped);
      end
    end
  end

  assign o_stat_accepted = r_stat_accepted;
  assign o_stat_dropped  = r_stat_dropped;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule
